seq_mult_ctrl: RTL
==================

Name: seq_mult_ctrl

Overview:
- FSM control unit for the ALU's 32-bit shift-add sequential multiplier datapath (multiplicand register, 64-bit product/multiplier shift register, 32-bit adder).
- Accepts a start pulse and sequences the datapath through WIDTH add/shift iterations.
- Reports completion with a one-cycle done pulse.
- Contains no datapath itself; drives only enables, and receives one status bit (product LSB) back.

Parameters:
- WIDTH, 32, operand width; number of add/shift iterations.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- mult_lsb  input  1  bit 0 of the product/multiplier register, from the datapath
- busy  output  1  high from INIT through DONE inclusive
- load_en  output  1  load operands into datapath registers; clear upper product half
- add_en  output  1  write adder result into upper product half
- shift_en  output  1  shift product register right by one
- done  output  1  one-cycle completion pulse
- iter_cnt  output  CNT_W  current iteration index, 0..WIDTH-1

Behaviour:
- One clock, clk. Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values: state=IDLE, iter_cnt=0. busy, load_en, add_en, shift_en and done are all 0.
- States: IDLE, INIT, TEST, SHIFT, DONE. Encoding constants live in the shared include.
- IDLE: all enables 0. If start=1, go to INIT; otherwise stay in IDLE.
- INIT: load_en=1, iter_cnt<=0, busy=1. Go to TEST.
- TEST: add_en = mult_lsb (Mealy output, same cycle). busy=1. Go to SHIFT.
- SHIFT: shift_en=1, busy=1.
  - If iter_cnt == WIDTH-1, go to DONE and wrap iter_cnt to 0.
  - Otherwise increment iter_cnt and go to TEST.
- DONE: done=1, busy=1. Go to IDLE unconditionally.
- All outputs except add_en are Moore (decoded from state only).
- At most one of load_en, add_en and shift_en is high in any cycle.
- Latency, with start sampled in cycle 0:
  - INIT in cycle 1.
  - TEST/SHIFT pairs in cycles 2..2*WIDTH+1.
  - done in cycle 2*WIDTH+2, i.e. cycle 66 for WIDTH=32.
- Latency is fixed and independent of operand values; there is no early termination.
- Exactly WIDTH shift_en pulses per operation. add_en pulses equal the number of TEST cycles that sampled mult_lsb=1.
- start while busy: ignored, never queued, no effect on the running operation.
- start held high continuously: a new operation begins in the cycle after DONE, which is spent in IDLE. Back-to-back period is 2*WIDTH+3 cycles.
- Reset mid-operation: state returns to IDLE and all outputs go to 0 on that edge. No done pulse is produced for the aborted operation.
- Reset together with start: reset wins.
- mult_lsb is don't-care in every state except TEST.
- Counter wrap: iter_cnt never exceeds WIDTH-1. The terminal compare uses WIDTH-1 at CNT_W bits.

Decomposition:
- Shared include seq_mult_defs.vh holds:
  - state encodings (S_IDLE..S_DONE, 3-bit);
  - the default WIDTH and CNT_W values, shared with the datapath modules.
- One natural sub-module: iter_counter, a CNT_W-bit counter with synchronous clear, increment enable and terminal-count flag (tc = cnt==WIDTH-1).
- The FSM next-state and output logic stays in seq_mult_ctrl.

Test Plan:
- Reset check: assert reset for 2 cycles → all outputs 0 and iter_cnt=0. Then start=1 for 1 cycle → load_en=1 in cycle 1 and done=1 exactly in cycle 66.
- Operands 7×5: datapath mult_lsb model follows 5=0b101 shifting right → add_en high in iterations 0 and 2 only. Exactly 32 shift_en pulses, 2 add_en pulses, product checked = 35.
- Operands 0xFFFFFFFF×0xFFFFFFFF → add_en in all 32 TEST cycles, product = 0xFFFFFFFE00000001, done still in cycle 66.
- start re-pulsed in cycles 10 and 40 during an operation → no second load_en, done only in cycle 66, busy low in cycle 67.
- start held high for 200 cycles → done pulses in cycles 66, 133 and 200. busy low only in cycles 67 and 134.
- reset asserted in cycle 30 (mid-SHIFT) → IDLE with all outputs 0 in cycle 31, no done pulse. A new start in cycle 35 → done in cycle 101.

Source files
------------

// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential multiplier: state encodings and the
// default operand width used by the controller and the datapath modules.
package seq_mult_ctrl_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_TEST  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/seq_mult_ctrl_iter_counter.sv
// Iteration counter for the multiplier: synchronous clear, increment enable
// and a terminal-count flag raised on the last iteration.
module iter_counter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift-add multiplier: sequences load, WIDTH test/shift
// pairs and a one-cycle done pulse; the datapath lives elsewhere.
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mult_lsb,
  output logic             busy,
  output logic             load_en,
  output logic             add_en,
  output logic             shift_en,
  output logic             done,
  output logic [CNT_W-1:0] iter_cnt
);

  state_e state_q, state_d;
  logic   cnt_clr, cnt_inc, cnt_tc;

  iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (iter_cnt),
    .tc_o  (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // add_en is the only Mealy output; everything else decodes state alone.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    load_en  = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        busy    = 1'b1;
        load_en = 1'b1;
        cnt_clr = 1'b1;
        state_d = S_TEST;
      end
      S_TEST: begin
        busy    = 1'b1;
        add_en  = mult_lsb;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (cnt_tc) begin
          cnt_clr = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_inc = 1'b1;
          state_d = S_TEST;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
